// File: rtl/note_seq_if.sv
// Bus bundle for note_sequencer: playback commands, program tick, song
// memory read port and the audio/status outputs.
// master = controller/memory side, slave = the sequencer itself.
interface note_seq_if #(
    parameter int ADDR_W = 8,
    parameter int DUR_W  = 8
) ();
    logic                tick;
    logic                cmd_play;
    logic                cmd_pause;
    logic                cmd_stop;
    logic [ADDR_W-1:0]   song_base;
    logic                mem_rd;
    logic [ADDR_W-1:0]   mem_addr;
    logic [9+DUR_W-1:0]  mem_data;
    logic [8:0]          notes_out;
    logic                playing;
    logic                busy;
    logic                song_done;

    modport master (
        output tick, cmd_play, cmd_pause, cmd_stop, song_base, mem_data,
        input  mem_rd, mem_addr, notes_out, playing, busy, song_done
    );

    modport slave (
        input  tick, cmd_play, cmd_pause, cmd_stop, song_base, mem_data,
        output mem_rd, mem_addr, notes_out, playing, busy, song_done
    );
endinterface

// File: rtl/note_sequencer.sv
// note_sequencer: walks a song table in memory, one entry per note
// ({duration, notes}), holding each note for `duration` program ticks with
// an optional silent gap between entries. Supports play/pause/stop.
// Optional feature macro SEQ_LOOP_EN: restart at the captured song base on
// the end marker instead of finishing.
module note_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int DUR_W     = 8,
    parameter int GAP_TICKS = 1
) (
    input  logic     clk,
    input  logic     sys_rst_n,
    note_seq_if.slave bus
);
    localparam int GAP_W = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_TICKS);
    localparam bit   LEGATO = (GAP_TICKS == 0);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_PLAY, S_GAP, S_PAUSED
    } state_t;

    state_t             state_q, state_d;
    state_t             ret_q, ret_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [8:0]         cur_q, cur_d;       // notes of the entry being played
    logic [8:0]         notes_q, notes_d;
    logic [DUR_W-1:0]   dur_q, dur_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic               rd_q, rd_d;
    logic               playing_q, playing_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SEQ_LOOP_EN
    logic [ADDR_W-1:0]  base_q, base_d;     // song start, for looping
    logic               first_q, first_d;   // next LATCH is the song's first entry
`endif

    logic [8:0]         ent_notes;
    logic [DUR_W-1:0]   ent_dur;
    assign ent_notes = bus.mem_data[8:0];
    assign ent_dur   = bus.mem_data[9+DUR_W-1:9];

    // State register and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!sys_rst_n) begin
            state_q   <= S_IDLE;
            ret_q     <= S_IDLE;
            addr_q    <= '0;
            cur_q     <= '0;
            notes_q   <= '0;
            dur_q     <= '0;
            gap_q     <= '0;
            rd_q      <= 1'b0;
            playing_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SEQ_LOOP_EN
            base_q    <= '0;
            first_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            addr_q    <= addr_d;
            cur_q     <= cur_d;
            notes_q   <= notes_d;
            dur_q     <= dur_d;
            gap_q     <= gap_d;
            rd_q      <= rd_d;
            playing_q <= playing_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef SEQ_LOOP_EN
            base_q    <= base_d;
            first_q   <= first_d;
`endif
        end
    end

    // Next state and counters; outputs are derived from the next state so
    // they can be registered. Stop beats pause beats play; a tick arriving
    // with an accepted command is dropped.
    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        addr_d  = addr_q;
        cur_d   = cur_q;
        dur_d   = dur_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
`ifdef SEQ_LOOP_EN
        base_d  = base_q;
        first_d = first_q;
`endif
        if (bus.cmd_stop) begin
            state_d = S_IDLE;
            dur_d   = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.cmd_play) begin
                        state_d = S_FETCH;
                        addr_d  = bus.song_base;
`ifdef SEQ_LOOP_EN
                        base_d  = bus.song_base;
                        first_d = 1'b1;
`endif
                    end
                end
                S_FETCH: state_d = S_LATCH;
                S_LATCH: begin
                    if (ent_dur == '0) begin
`ifdef SEQ_LOOP_EN
                        // An empty song still finishes; otherwise loop.
                        if (first_q) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_FETCH;
                            addr_d  = base_q;
                        end
`else
                        done_d  = 1'b1;
                        state_d = S_IDLE;
`endif
                    end else begin
                        cur_d   = ent_notes;
                        dur_d   = ent_dur;
                        state_d = S_PLAY;
`ifdef SEQ_LOOP_EN
                        first_d = 1'b0;
`endif
                    end
                end
                S_PLAY: begin
                    if (bus.cmd_pause) begin
                        ret_d   = S_PLAY;
                        state_d = S_PAUSED;
                    end else if (bus.tick) begin
                        if (dur_q == DUR_W'(1)) begin
                            dur_d = '0;
                            if (LEGATO) begin
                                state_d = S_FETCH;
                                addr_d  = addr_q + 1'b1;
                            end else begin
                                state_d = S_GAP;
                                gap_d   = GAP_INIT;
                            end
                        end else begin
                            dur_d = dur_q - 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (bus.cmd_pause) begin
                        ret_d   = S_GAP;
                        state_d = S_PAUSED;
                    end else if (bus.tick) begin
                        if (gap_q <= GAP_W'(1)) begin
                            gap_d   = '0;
                            state_d = S_FETCH;
                            addr_d  = addr_q + 1'b1;
                        end else begin
                            gap_d = gap_q - 1'b1;
                        end
                    end
                end
                S_PAUSED: begin
                    if (!bus.cmd_pause && bus.cmd_play) state_d = ret_q;
                end
                default: state_d = S_IDLE;
            endcase
        end

        notes_d   = (state_d == S_PLAY) ? cur_d : 9'd0;
        rd_d      = (state_d == S_FETCH);
        playing_d = (state_d == S_PLAY) || (state_d == S_GAP);
        busy_d    = (state_d != S_IDLE);
    end

    assign bus.mem_rd    = rd_q;
    assign bus.mem_addr  = addr_q;
    assign bus.notes_out = notes_q;
    assign bus.playing   = playing_q;
    assign bus.busy      = busy_q;
    assign bus.song_done = done_q;
endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, song memory address width.
REQ-002 Parameter DUR_W, default 8, note duration width in ticks.
REQ-003 Parameter GAP_TICKS, default 1, silent ticks between consecutive entries; 0 = legato.
REQ-004 clk  in  1  system clock; single clock domain for the block.
REQ-005 sys_rst_n  in  1  reset, synchronous, active-low.
REQ-006 tick  in  1  one-clk pulse per program tick, i.e. the prog_clk rising edge already synchronised into the clk domain.
REQ-007 cmd_play  in  1  start from IDLE or resume from PAUSED; level sampled every clk.
REQ-008 cmd_pause  in  1  pause request.
REQ-009 cmd_stop  in  1  abort request.
REQ-010 song_base  in  ADDR_W  address of the first song entry; sampled only on start.
REQ-011 mem_rd  out  1  song memory read strobe.
REQ-012 mem_addr  out  ADDR_W  song memory address.
REQ-013 mem_data  in  9+DUR_W  entry: [8:0] Notes (bits 6:0 note keys, bit 7 octave up, bit 8 octave down); [9+DUR_W-1:9] duration; valid exactly 1 clk after mem_rd.
REQ-014 notes_out  out  9  Notes word driven to the audio output path.
REQ-015 playing  out  1  high while in PLAY or GAP.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 song_done  out  1  one-clk pulse on normal end of song.

Function
REQ-018 States IDLE, FETCH, LATCH, PLAY, GAP, PAUSED; all outputs are registered.
REQ-019 IDLE: cmd_play -> FETCH with mem_addr=song_base.
REQ-020 FETCH: mem_rd=1 for exactly one clk -> LATCH.
REQ-021 LATCH: if duration==0 (end marker) -> end-of-song handling; otherwise notes_out<=entry notes, dur_cnt<=duration -> PLAY.
REQ-022 Start latency: cmd_play sampled at cycle N; mem_rd=1 at N+1; notes_out valid and playing=1 at N+3.
REQ-023 PLAY: each tick decrements dur_cnt; the tick that takes it to 0 clears notes_out and enters GAP with gap_cnt=GAP_TICKS, or enters FETCH at mem_addr+1 if GAP_TICKS==0.
REQ-024 Each entry therefore sounds for exactly `duration` ticks.
REQ-025 GAP: notes_out=0; each tick decrements gap_cnt; reaching 0 -> FETCH at mem_addr+1.
REQ-026 mem_addr increments modulo 2^ADDR_W and wraps from all-ones to 0 without error.
REQ-027 Command priority: cmd_stop > cmd_pause > cmd_play. A tick coincident with an accepted command is not counted.
REQ-028 cmd_stop in any state -> IDLE next clk: notes_out=0, mem_rd=0, no song_done pulse.
REQ-029 cmd_pause in PLAY or GAP -> PAUSED: notes_out=0, dur_cnt/gap_cnt/mem_addr frozen, return state recorded; ignored in IDLE, FETCH and LATCH.
REQ-030 PAUSED: cmd_play -> recorded state with counters unchanged; on return to PLAY, notes_out is restored to the paused entry's notes.
REQ-031 cmd_play outside IDLE and PAUSED is ignored; it never restarts playback.
REQ-032 Empty song (end marker at song_base, first fetch): song_done pulses and the block returns to IDLE, regardless of configuration.

Reset
REQ-033 sys_rst_n low at a clk edge: state=IDLE; notes_out=0; mem_addr=0; mem_rd=0; playing=0; busy=0; song_done=0; all counters 0.
REQ-034 Reset mid-playback takes effect on that edge; the read data of any in-flight read is discarded.

Configuration
REQ-035 Macro SEQ_LOOP_EN defined: on a non-empty song's end marker, go to FETCH at song_base (the value captured at start); no song_done pulse; playback continues until stopped.
REQ-036 SEQ_LOOP_EN undefined: on the end marker, pulse song_done for 1 clk, notes_out=0, go to IDLE.

Verification
REQ-037 Song at base 0x10 = {C4 (0x001), dur 3}, {E4 (0x004), dur 2}, end; GAP_TICKS=1; tick every 4 clk -> notes_out=0x001 for 3 ticks, 0 for 1 tick, 0x004 for 2 ticks; then (loop off) song_done pulse, busy=0.
REQ-038 cmd_play at cycle N -> mem_rd=1 at N+1 with mem_addr=song_base; notes_out valid at N+3.
REQ-039 cmd_pause after 1 of 3 ticks, hold 10 ticks, then cmd_play -> notes_out=0 while paused; after resume the note sounds for exactly 2 more ticks.
REQ-040 cmd_stop and cmd_pause asserted together during PLAY -> IDLE next clk, notes_out=0, no song_done.
REQ-041 song_base=0xFF, entries at 0xFF and 0x00, end marker at 0x01 -> fetch order 0xFF, 0x00, 0x01.
REQ-042 SEQ_LOOP_EN defined, 2-entry song -> after the end marker mem_addr returns to song_base; no song_done pulse; playback continues until cmd_stop.
